cache_ram_arbiter: RTL and testbench

CACHE_RAM_ARBITER -- requirements
Module: cache_ram_arbiter

---
 rtl/cache_ram_arbiter.sv | 129 ++++++++++++
 tb/tb_cache_ram_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_ram_arbiter.sv
// cache_ram_arbiter: round-robin arbiter letting two cache ports share one RAM.
// A read fills a whole block, word by word; a write stores a single word.
module cache_ram_arbiter #(
    parameter int RAM_ADDRESS_BITS = 10,
    parameter int DATA_BITS = 32,
    parameter int BLOCK_BITS = 2,
    localparam int BLOCK_SIZE = 2 ** BLOCK_BITS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic [1:0] req_read_en,
    input  logic [1:0] req_write_en,
    input  logic [RAM_ADDRESS_BITS-1:0] req_address_0,
    input  logic [RAM_ADDRESS_BITS-1:0] req_address_1,
    input  logic [DATA_BITS-1:0] req_write_data_0,
    input  logic [DATA_BITS-1:0] req_write_data_1,
    output logic [1:0] resp_valid,
    output logic [BLOCK_SIZE-1:0][DATA_BITS-1:0] resp_data_0,
    output logic [BLOCK_SIZE-1:0][DATA_BITS-1:0] resp_data_1,
    output logic [RAM_ADDRESS_BITS-1:0] mem_address,
    output logic mem_read_en,
    output logic mem_write_en,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic [DATA_BITS-1:0] mem_read_data,
    input  logic mem_ack,
    output logic busy,
    output logic grant
);
    typedef enum logic [1:0] {IDLE, READ_BURST, WRITE_WORD, RESPOND} state_t;
    state_t state, state_n;
    logic [BLOCK_BITS-1:0] counter, counter_n;
    logic last_grant, last_grant_n, grant_n, after_resp, after_resp_n, busy_n;
    logic mem_read_en_n, mem_write_en_n, pick;
    logic [1:0] live, resp_valid_n;
    logic [RAM_ADDRESS_BITS-1:0] mem_address_n, pick_address;
    logic [DATA_BITS-1:0] mem_write_data_n;
    logic [BLOCK_SIZE-1:0][DATA_BITS-1:0] words, words_n, resp_data_0_n, resp_data_1_n;

    // the port served last is ignored for the one idle cycle after its response
    assign live = (req_read_en | req_write_en) & ~{after_resp & grant, after_resp & ~grant};
    assign pick = (live == 2'b11) ? ~last_grant : live[1];
    assign pick_address = pick ? req_address_1 : req_address_0;

    always_comb begin
        state_n = state;
        counter_n = counter;
        last_grant_n = last_grant;
        grant_n = grant;
        after_resp_n = 1'b0;
        mem_address_n = mem_address;
        mem_read_en_n = mem_read_en;
        mem_write_en_n = mem_write_en;
        mem_write_data_n = mem_write_data;
        resp_valid_n = 2'b00;
        words_n = words;
        resp_data_0_n = resp_data_0;
        resp_data_1_n = resp_data_1;
        case (state)
            IDLE: if (|live) begin
                grant_n = pick;
                last_grant_n = pick;
                counter_n = '0;
                mem_write_data_n = pick ? req_write_data_1 : req_write_data_0;
                state_n = req_write_en[pick] ? WRITE_WORD : READ_BURST;
                mem_write_en_n = req_write_en[pick];
                mem_read_en_n = ~req_write_en[pick];
                mem_address_n = req_write_en[pick] ? pick_address
                              : {pick_address[RAM_ADDRESS_BITS-1:BLOCK_BITS], {BLOCK_BITS{1'b0}}};
            end
            READ_BURST: if (mem_ack) begin
                words_n[counter] = mem_read_data;
                counter_n = counter + BLOCK_BITS'(1);
                mem_address_n = {mem_address[RAM_ADDRESS_BITS-1:BLOCK_BITS], counter_n};
                if (&counter) begin
                    state_n = RESPOND;
                    mem_read_en_n = 1'b0;
                    resp_valid_n[grant] = 1'b1;
                    resp_data_0_n = grant ? resp_data_0 : words_n;
                    resp_data_1_n = grant ? words_n : resp_data_1;
                end
            end
            WRITE_WORD: if (mem_ack) begin
                state_n = RESPOND;
                mem_write_en_n = 1'b0;
                resp_valid_n[grant] = 1'b1;
            end
            RESPOND: begin
                state_n = IDLE;
                after_resp_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        busy_n = state_n != IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            counter <= '0;
            last_grant <= 1'b1;
            grant <= 1'b0;
            after_resp <= 1'b0;
            busy <= 1'b0;
            mem_address <= '0;
            mem_read_en <= 1'b0;
            mem_write_en <= 1'b0;
            mem_write_data <= '0;
            resp_valid <= 2'b00;
            words <= '0;
            resp_data_0 <= '0;
            resp_data_1 <= '0;
        end else begin
            state <= state_n;
            counter <= counter_n;
            last_grant <= last_grant_n;
            grant <= grant_n;
            after_resp <= after_resp_n;
            busy <= busy_n;
            mem_address <= mem_address_n;
            mem_read_en <= mem_read_en_n;
            mem_write_en <= mem_write_en_n;
            mem_write_data <= mem_write_data_n;
            resp_valid <= resp_valid_n;
            words <= words_n;
            resp_data_0 <= resp_data_0_n;
            resp_data_1 <= resp_data_1_n;
        end
    end
endmodule

// File: tb/tb_cache_ram_arbiter.sv
// tb_cache_ram_arbiter: scoreboard bench; RAM returns its own word address as data.
module tb_cache_ram_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    logic [1:0] req_read_en, req_write_en, resp_valid;
    logic [9:0] req_address_0, req_address_1, mem_address;
    logic [31:0] req_write_data_0, req_write_data_1, mem_write_data, mem_read_data;
    logic [3:0][31:0] resp_data_0, resp_data_1;
    logic mem_read_en, mem_write_en, mem_ack, busy, grant, ack_en;

    typedef struct packed {logic wr; logic [9:0] addr; logic [31:0] data;} mem_t;
    typedef struct packed {logic port; logic [127:0] data;} resp_t;
    mem_t mem_q[$];
    resp_t resp_q[$];
    mem_t me;
    resp_t re;
    logic [127:0] blk [2];
    int n_cmp = 0, n_err = 0, cyc;

    cache_ram_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req_read_en(req_read_en), .req_write_en(req_write_en),
        .req_address_0(req_address_0), .req_address_1(req_address_1),
        .req_write_data_0(req_write_data_0), .req_write_data_1(req_write_data_1),
        .resp_valid(resp_valid), .resp_data_0(resp_data_0), .resp_data_1(resp_data_1),
        .mem_address(mem_address), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .mem_ack(mem_ack),
        .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;
    assign mem_ack = ack_en & (mem_read_en | mem_write_en);
    assign mem_read_data = 32'(mem_address);

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_read(input int p, input logic [9:0] a);
        for (int w = 0; w < 4; w++) begin
            mem_q.push_back({1'b0, {a[9:2], 2'(w)}, 32'h0});
            blk[p][w*32 +: 32] = 32'({a[9:2], 2'(w)});
        end
        resp_q.push_back({p[0], blk[p]});
    endtask

    task automatic exp_write(input int p, input logic [9:0] a, input logic [31:0] d);
        mem_q.push_back({1'b1, a, d});
        resp_q.push_back({p[0], blk[p]});
    endtask

    task automatic wait_resp(input int p, input int hold, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid[p] && n < 100);
        check("resp_seen", resp_valid[p], 1);
        repeat (hold + 1) tick();
        req_read_en[p] = 1'b0;
        req_write_en[p] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mem_read_en || mem_write_en) begin
            check("mem_excl", mem_read_en & mem_write_en, 0);
            if (mem_ack) begin
                if (mem_q.size() == 0) check("mem_unexpected", mem_address, 0);
                else begin
                    me = mem_q.pop_front();
                    check("mem_addr", mem_address, me.addr);
                    check("mem_wr", mem_write_en, me.wr);
                    if (me.wr) check("mem_wdata", mem_write_data, me.data);
                end
            end
        end
        if (resp_valid != 2'b00) begin
            if (resp_q.size() == 0) check("resp_unexpected", resp_valid, 0);
            else begin
                re = resp_q.pop_front();
                check("resp_port", resp_valid, re.port ? 2'b10 : 2'b01);
                check("resp_data", re.port ? resp_data_1 : resp_data_0, re.data);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        ack_en = 1'b1;
        req_read_en = 2'b00;
        req_write_en = 2'b00;
        req_address_0 = '0;
        req_address_1 = '0;
        req_write_data_0 = '0;
        req_write_data_1 = '0;
        blk[0] = '0;
        blk[1] = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_mem_re", mem_read_en, 0);
        check("rst_mem_we", mem_write_en, 0);
        check("rst_mem_addr", mem_address, 0);
        check("rst_mem_wdata", mem_write_data, 0);
        check("rst_resp_data_0", resp_data_0, 0);
        check("rst_resp_data_1", resp_data_1, 0);
        tick();
        reset_n = 1'b1;
        tick();
        // simultaneous reads after reset: port 0 first, then port 1, twice
        for (int t = 0; t < 2; t++) begin
            req_address_0 = t ? 10'h040 : 10'h013;
            req_address_1 = t ? 10'h0FC : 10'h0A6;
            req_read_en = 2'b11;
            exp_read(0, req_address_0);
            exp_read(1, req_address_1);
            wait_resp(0, 0, cyc);
            wait_resp(1, 0, cyc);
            tick();
        end
        // single read of 0x2B, request held one cycle past the response
        req_address_0 = 10'h02B;
        req_read_en[0] = 1'b1;
        exp_read(0, 10'h02B);
        wait_resp(0, 1, cyc);
        check("read_latency", cyc, 6);
        @(negedge clk);
        check("no_regrant_busy", busy, 0);
        check("blk_2b", resp_data_0, 128'h0000002B_0000002A_00000029_00000028);
        tick();
        // port 1 write (read also asserted; write wins) with ack held off 3 cycles
        ack_en = 1'b0;
        req_address_1 = 10'h3FF;
        req_write_data_1 = 32'hDEADBEEF;
        req_write_en[1] = 1'b1;
        req_read_en[1] = 1'b1;
        exp_write(1, 10'h3FF, 32'hDEADBEEF);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wr_held", mem_write_en, 1);
            check("wr_grant", grant, 1);
            tick();
        end
        ack_en = 1'b1;
        wait_resp(1, 0, cyc);
        tick();
        // read stalled after word 1; address change after grant must be ignored
        req_address_1 = 10'h155;
        req_read_en[1] = 1'b1;
        exp_read(1, 10'h155);
        repeat (3) tick();
        req_address_1 = 10'h000;
        ack_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_addr", mem_address, 10'h156);
            check("stall_re", mem_read_en, 1);
            tick();
        end
        ack_en = 1'b1;
        wait_resp(1, 0, cyc);
        tick();
        // reset during word 2 of a burst aborts it without a response
        req_address_0 = 10'h100;
        req_read_en[0] = 1'b1;
        for (int w = 0; w < 3; w++) mem_q.push_back({1'b0, 10'h100 + 10'(w), 32'h0});
        repeat (3) tick();
        reset_n = 1'b0;
        req_read_en = 2'b00;
        tick();
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_re", mem_read_en, 0);
        check("abort_resp_valid", resp_valid, 0);
        check("abort_resp_data_0", resp_data_0, 0);
        check("abort_resp_data_1", resp_data_1, 0);
        blk[0] = '0;
        blk[1] = '0;
        tick();
        reset_n = 1'b1;
        tick();
        // tie after reset: port 0 read wins, then port 1 write
        req_address_0 = 10'h200;
        req_address_1 = 10'h3FD;
        req_write_data_1 = 32'h12345678;
        req_read_en[0] = 1'b1;
        req_write_en[1] = 1'b1;
        exp_read(0, 10'h200);
        exp_write(1, 10'h3FD, 32'h12345678);
        wait_resp(0, 0, cyc);
        wait_resp(1, 0, cyc);
        repeat (5) tick();
        check("mem_q_left", mem_q.size(), 0);
        check("resp_q_left", resp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
